// File: rtl/tdc_window_classifier.sv
// -----------------------------------------------------------------------------
// tdc_window_classifier
//   Multi-channel fine-time leading-edge decoder with per-channel time-window
//   classification and saturating per-window hit counters.
//
//   Every channel delivers a TAPS-bit thermometer-like sample word. An edge
//   at tap k is a run of EDGE_LEN ones starting at k and followed by a zero.
//   Tap indices wrap around the word. The pipeline is two cycles deep:
//     stage 1 : registered per-tap edge decode (gated by samp_vld)
//     stage 2 : registered edge_vld / edge_pos / edge_multi / match pulses
//
// Ports
//   clk        : system clock, all logic on rising edge
//   rst        : synchronous active-high reset
//   samp       : NCH packed sample words, channel c = samp[c*TAPS +: TAPS]
//   samp_vld   : per-channel "word is a new hit"
//   edge_vld   : per-channel 1-cycle pulse, at least one edge decoded
//   edge_pos   : per-channel 5-bit lowest decoded edge index
//   edge_multi : per-channel, more than one edge in the word
//   match      : match[c*NWIN+w], enabled window w hit on channel c
//   DataIn     : bus write data
//   DataOut    : bus read data, 0 when not addressed
//   Address    : bus address, channel c slot s at BASE + c*8 + s
//   Read/Write : bus strobes
//   ack        : 1-cycle pulse the cycle after an addressed access
//
// Register map per channel
//   slot 0          CFG   [NWIN-1:0] window enables, bit31 write-1 clears counters
//   slot 1..NWIN    MASKw (TAPS bits, RW)
//   slot 5..4+NWIN  CNTw  (16 bits, RO)
// -----------------------------------------------------------------------------
module tdc_window_classifier #(
  parameter int          NCH      = 4,
  parameter int          TAPS     = 32,
  parameter int          NWIN     = 3,
  parameter int          EDGE_LEN = 3,
  parameter logic [7:0]  BASE     = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*TAPS-1:0]    samp,
  input  logic [NCH-1:0]         samp_vld,
  output logic [NCH-1:0]         edge_vld,
  output logic [NCH*5-1:0]       edge_pos,
  output logic [NCH-1:0]         edge_multi,
  output logic [NCH*NWIN-1:0]    match,
  input  logic [31:0]            DataIn,
  output logic [31:0]            DataOut,
  input  logic [7:0]             Address,
  input  logic                   Read,
  input  logic                   Write,
  output logic                   ack
);

  localparam logic [TAPS-1:0] ONE_T = {{(TAPS-1){1'b0}}, 1'b1};

  function automatic logic [TAPS-1:0] f_mask_rst(input int w);
    logic [31:0] l_v;
    case (w)
      0:       l_v = 32'hFFFF_FFFF;
      1:       l_v = 32'h0000_F000;
      default: l_v = 32'h0F00_0000;
    endcase
    return l_v[TAPS-1:0];
  endfunction

  // configuration and status
  logic [NWIN-1:0]  r_cfg  [NCH];
  logic [TAPS-1:0]  r_mask [NCH][NWIN];
  logic [15:0]      r_cnt  [NCH][NWIN];

  // pipeline
  logic [TAPS-1:0]       r_decode [NCH];
  logic [NCH-1:0]        r_edge_vld;
  logic [NCH*5-1:0]      r_edge_pos;
  logic [NCH-1:0]        r_edge_multi;
  logic [NCH*NWIN-1:0]   r_match;
  logic                  r_ack;

  logic [TAPS-1:0]  w_decode [NCH];
  logic [NCH-1:0]   w_any;
  logic [4:0]       w_pos   [NCH];
  logic [NCH-1:0]   w_multi;
  logic [NWIN-1:0]  w_match [NCH];

  // bus decode
  logic [8:0]       w_diff;
  logic             w_hit;
  logic [2:0]       w_ch;
  logic [2:0]       w_slot;
  logic [NCH-1:0]   w_wr_ch;
  logic [NCH-1:0]   w_clr;
  logic [31:0]      w_rdata;

  // ---------------------------------------------------------------------------
  // Stage 1: wrap-around edge decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_decode = '{default: '0};
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < TAPS; k++) begin
        logic l_run;
        l_run = 1'b1;
        for (int i = 0; i < EDGE_LEN; i++) begin
          l_run = l_run & samp[c*TAPS + ((k + i) % TAPS)];
        end
        w_decode[c][k] = samp_vld[c] & l_run & ~samp[c*TAPS + ((k + EDGE_LEN) % TAPS)];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: priority encode, multi-edge detect, window classification.
  // Uses the live CFG/MASK registers, so a write lands on the following word.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_any   = '0;
    w_multi = '0;
    w_pos   = '{default: '0};
    w_match = '{default: '0};
    for (int c = 0; c < NCH; c++) begin
      w_any[c] = |r_decode[c];
      // clearing the lowest set bit leaves something only if >1 bit was set
      w_multi[c] = |(r_decode[c] & (r_decode[c] - ONE_T));
      for (int k = TAPS - 1; k >= 0; k--) begin
        if (r_decode[c][k]) w_pos[c] = 5'(k);
      end
      for (int w = 0; w < NWIN; w++) begin
        w_match[c][w] = (|(r_decode[c] & r_mask[c][w])) & r_cfg[c][w];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus address decode and read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    // 9-bit subtract: bit 8 set means Address is below BASE
    w_diff  = {1'b0, Address} - {1'b0, BASE};
    w_hit   = !w_diff[8] && (w_diff[7:0] < 8'(NCH*8));
    w_ch    = w_diff[5:3];
    w_slot  = w_diff[2:0];
    w_wr_ch = '0;
    w_clr   = '0;
    w_rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_hit && (w_ch == 3'(c))) begin
        w_wr_ch[c] = Write;
        w_clr[c]   = Write && (w_slot == 3'd0) && DataIn[31];
        if (Read) begin
          if (w_slot == 3'd0) w_rdata = 32'(r_cfg[c]);
          for (int w = 0; w < NWIN; w++) begin
            if (w_slot == 3'(w + 1)) w_rdata = 32'(r_mask[c][w]);
            if (w_slot == 3'(w + 5)) w_rdata = {16'h0, r_cnt[c][w]};
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_decode     <= '{default: '0};
      r_edge_vld   <= '0;
      r_edge_pos   <= '0;
      r_edge_multi <= '0;
      r_match      <= '0;
      r_ack        <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_cfg[c] <= '1;
        for (int w = 0; w < NWIN; w++) begin
          r_mask[c][w] <= f_mask_rst(w);
          r_cnt[c][w]  <= '0;
        end
      end
    end else begin
      r_ack <= (Read || Write) && w_hit;
      for (int c = 0; c < NCH; c++) begin
        r_decode[c]           <= w_decode[c];
        r_edge_vld[c]         <= w_any[c];
        r_edge_pos[c*5 +: 5]  <= w_pos[c];
        r_edge_multi[c]       <= w_multi[c];
        r_match[c*NWIN +: NWIN] <= w_match[c];

        if (w_wr_ch[c]) begin
          if (w_slot == 3'd0) r_cfg[c] <= DataIn[NWIN-1:0];
          for (int w = 0; w < NWIN; w++) begin
            if (w_slot == 3'(w + 1)) r_mask[c][w] <= DataIn[TAPS-1:0];
          end
        end

        // counters advance with the match pulse being registered; clear wins
        for (int w = 0; w < NWIN; w++) begin
          if (w_clr[c]) begin
            r_cnt[c][w] <= '0;
          end else if (w_match[c][w] && (r_cnt[c][w] != 16'hFFFF)) begin
            r_cnt[c][w] <= r_cnt[c][w] + 16'd1;
          end
        end
      end
    end
  end

  assign edge_vld   = r_edge_vld;
  assign edge_pos   = r_edge_pos;
  assign edge_multi = r_edge_multi;
  assign match      = r_match;
  assign ack        = r_ack;
  assign DataOut    = w_rdata;

endmodule

// File: tb/tb_tdc_window_classifier.sv
// -----------------------------------------------------------------------------
// tb_tdc_window_classifier
//   Scoreboard bench. Stimulus tasks push expected hit results and expected
//   bus acks into queues; a negedge monitor pops and compares whenever the
//   DUT pulses an output.
// -----------------------------------------------------------------------------
module tb_tdc_window_classifier;

  localparam int NCH  = 4;
  localparam int TAPS = 32;
  localparam int NWIN = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH*TAPS-1:0]   samp;
  logic [NCH-1:0]        samp_vld;
  logic [NCH-1:0]        edge_vld;
  logic [NCH*5-1:0]      edge_pos;
  logic [NCH-1:0]        edge_multi;
  logic [NCH*NWIN-1:0]   match;
  logic [31:0]           DataIn;
  logic [31:0]           DataOut;
  logic [7:0]            Address;
  logic                  Read;
  logic                  Write;
  logic                  ack;

  tdc_window_classifier #(
    .NCH(NCH), .TAPS(TAPS), .NWIN(NWIN), .EDGE_LEN(3), .BASE(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .samp(samp), .samp_vld(samp_vld),
    .edge_vld(edge_vld), .edge_pos(edge_pos), .edge_multi(edge_multi),
    .match(match), .DataIn(DataIn), .DataOut(DataOut), .Address(Address),
    .Read(Read), .Write(Write), .ack(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    int              ch;
    logic [4:0]      pos;
    logic            multi;
    logic [NWIN-1:0] m;
  } hit_t;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] d;
  } bus_t;

  hit_t hq[$];
  bus_t bq[$];

  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  bit          done  = 1'b0;
  logic [31:0] rd_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (edge_vld[c] || (match[c*NWIN +: NWIN] != '0)) begin
        total++;
        if (hq.size() == 0) begin
          bad++;
          $display("FAIL hit_unexpected ch%0d cyc=%0d got vld=%0b pos=%0d match=%b, want no pulse",
                   c, cyc, edge_vld[c], edge_pos[c*5 +: 5], match[c*NWIN +: NWIN]);
        end else begin
          hit_t h;
          h = hq.pop_front();
          if (h.cyc != cyc || h.ch != c || !edge_vld[c] || edge_pos[c*5 +: 5] != h.pos ||
              edge_multi[c] != h.multi || match[c*NWIN +: NWIN] != h.m) begin
            bad++;
            $display("FAIL hit ch%0d cyc=%0d got vld=%0b pos=%0d multi=%0b match=%b, want ch%0d cyc=%0d vld=1 pos=%0d multi=%0b match=%b",
                     c, cyc, edge_vld[c], edge_pos[c*5 +: 5], edge_multi[c],
                     match[c*NWIN +: NWIN], h.ch, h.cyc, h.pos, h.multi, h.m);
          end
        end
      end
    end

    if (ack) begin
      total++;
      if (bq.size() == 0) begin
        bad++;
        $display("FAIL ack_unexpected cyc=%0d got ack=1, want ack=0", cyc);
      end else begin
        bus_t b;
        b = bq.pop_front();
        if (b.cyc != cyc || (b.rd && rd_last != b.d)) begin
          bad++;
          $display("FAIL bus cyc=%0d got data=%h (rd=%0b), want cyc=%0d data=%h",
                   cyc, rd_last, b.rd, b.cyc, b.d);
        end
      end
    end

    if (Read) begin
      if (Address < 8'(NCH*8)) begin
        rd_last = DataOut;
      end else begin
        total++;
        if (DataOut != 32'h0) begin
          bad++;
          $display("FAIL unaddressed_read addr=%h got %h, want 00000000", Address, DataOut);
        end
      end
    end

    if (done) begin
      total++;
      if (hq.size() != 0 || bq.size() != 0) begin
        bad++;
        $display("FAIL missing_outputs got hits_left=%0d acks_left=%0d, want 0 and 0",
                 hq.size(), bq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    samp_vld = '0;
    Read     = 1'b0;
    Write    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic put(input int c, input logic [31:0] word, input bit exp,
                     input logic [4:0] pos, input logic multi, input logic [NWIN-1:0] m);
    samp[c*TAPS +: TAPS] = word;
    samp_vld[c]          = 1'b1;
    if (exp) hq.push_back('{cyc + 2, c, pos, multi, m});
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    Address = a; DataIn = d; Write = 1'b1;
    bq.push_back('{cyc + 1, 1'b0, 32'h0});
    step();
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp_d);
    Address = a; Read = 1'b1;
    bq.push_back('{cyc + 1, 1'b1, exp_d});
    step();
  endtask

  task automatic bus_rw(input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp_pre);
    Address = a; DataIn = d; Read = 1'b1; Write = 1'b1;
    bq.push_back('{cyc + 1, 1'b1, exp_pre});
    step();
  endtask

  task automatic bus_rd_unmapped(input logic [7:0] a);
    Address = a; Read = 1'b1;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; samp = '0; samp_vld = '0;
    DataIn = '0; Address = '0; Read = 1'b0; Write = 1'b0;

    // reset held while valid toggles: nothing may come out
    for (int i = 0; i < 6; i++) begin
      samp = {NCH{32'h0000_F000}};
      step();
      samp_vld = (i % 2 == 0) ? '1 : '0;
    end
    rst = 1'b0;
    idle(2);

    // reset values
    bus_rd(8'h00, 32'h0000_0007);
    bus_rd(8'h01, 32'hFFFF_FFFF);
    bus_rd(8'h02, 32'h0000_F000);
    bus_rd(8'h03, 32'h0F00_0000);
    bus_rd(8'h05, 32'h0000_0000);
    bus_rd(8'h1C, 32'h0000_0000);   // unused slot
    bus_rd_unmapped(8'h20);
    idle(2);

    // single edge
    put(0, 32'h0000_F000, 1, 5'd13, 1'b0, 3'b011); step();
    idle(3);
    bus_rd(8'h05, 32'd1);
    bus_rd(8'h06, 32'd1);
    bus_rd(8'h07, 32'd0);

    // wrap-around, all-ones, all-zeros, stale word
    put(0, 32'hC000_0001, 1, 5'd30, 1'b0, 3'b001); step();
    put(0, 32'hFFFF_FFFF, 0, 5'd0, 1'b0, 3'b000);  step();
    put(0, 32'h0000_0000, 0, 5'd0, 1'b0, 3'b000);  step();
    samp[31:0] = 32'h0000_F000; step();             // valid low
    idle(3);

    // two edges in one word
    put(0, 32'h000E_00E0, 1, 5'd5, 1'b1, 3'b001); step();
    idle(3);
    bus_rd(8'h05, 32'd3);
    bus_rd(8'h06, 32'd1);

    // back-to-back words and simultaneous channels
    put(2, 32'h0000_F000, 1, 5'd13, 1'b0, 3'b011);
    put(3, 32'hC000_0001, 1, 5'd30, 1'b0, 3'b001); step();
    put(2, 32'h7000_0000, 1, 5'd28, 1'b0, 3'b001); step();
    put(2, 32'h0700_0000, 1, 5'd24, 1'b0, 3'b101); step();
    idle(3);
    bus_rd(8'h15, 32'd3);
    bus_rd(8'h16, 32'd1);
    bus_rd(8'h17, 32'd1);
    bus_rd(8'h1D, 32'd1);

    // bus reconfiguration on ch1
    bus_wr(8'h0A, 32'h0000_00F0);
    bus_wr(8'h08, 32'h0000_0002);
    bus_rd(8'h0A, 32'h0000_00F0);
    bus_rd(8'h08, 32'h0000_0002);
    put(1, 32'h0000_00F0, 1, 5'd5, 1'b0, 3'b010); step();
    idle(3);
    bus_rw(8'h0B, 32'h1234_5678, 32'h0F00_0000);
    bus_rd(8'h0B, 32'h1234_5678);
    bus_wr(8'h05, 32'h0000_1234);   // RO counter
    bus_rd(8'h05, 32'd3);

    // saturation
    for (int i = 0; i < 65600; i++) begin
      put(0, 32'h0000_F000, 1, 5'd13, 1'b0, 3'b011); step();
    end
    idle(3);
    bus_rd(8'h05, 32'h0000_FFFF);
    bus_rd(8'h06, 32'h0000_FFFF);
    bus_rd(8'h07, 32'h0000_0000);

    // clear lands on the same edge as the increment
    put(0, 32'h0000_F000, 1, 5'd13, 1'b0, 3'b011); step();
    bus_wr(8'h00, 32'h8000_0007);
    idle(2);
    bus_rd(8'h05, 32'd0);
    bus_rd(8'h06, 32'd0);
    bus_rd(8'h00, 32'h0000_0007);

    // reset mid-stream
    idle(4);
    samp[31:0] = 32'h0000_F000; samp_vld[0] = 1'b1; step();  // in flight, discarded
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      samp = {NCH{32'h0000_F000}};
      samp_vld = (i % 2 == 0) ? '1 : '0;
      step();
    end
    rst = 1'b0;
    bus_rd(8'h08, 32'h0000_0007);
    bus_rd(8'h0A, 32'h0000_F000);
    bus_rd(8'h0B, 32'h0F00_0000);
    bus_rd(8'h07, 32'h0000_0000);
    put(0, 32'h0000_F000, 1, 5'd13, 1'b0, 3'b011); step();
    idle(3);
    bus_rd(8'h05, 32'd1);
    idle(3);

    done = 1'b1;
  end

endmodule
